// File: rtl/fpdiv_ctrl.sv
// rtl/fpdiv_ctrl.sv - sequencing controller for the Goldschmidt single-precision divider datapath
module fpdiv_ctrl #(
    parameter int NUM_ITER = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] inputNum,
    input  logic [31:0] inputDenom,
    input  logic        rm_in,
    output logic [31:0] num_q,
    output logic [31:0] denom_q,
    output logic        rm,
    output logic        en_a,
    output logic        en_b,
    output logic        en_rem,
    output logic [1:0]  sel_mux3,
    output logic [1:0]  sel_mux4,
    output logic        busy,
    output logic        done,
    output logic [2:0]  iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT_N = 3'd1,
        S_INIT_D = 3'd2,
        S_ITER_N = 3'd3,
        S_ITER_D = 3'd4,
        S_REM    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Index of the final refinement iteration; ITER_N leaves for REM when it is reached.
    localparam logic [2:0] LAST_ITER = 3'(NUM_ITER - 1);

    state_t      state_q, state_d;
    logic [2:0]  iter_cnt_q, iter_cnt_d;
    logic [31:0] num_d, denom_d;
    logic        rm_q, rm_d;

    // State, iteration counter and captured operands; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            iter_cnt_q <= 3'd0;
            num_q      <= 32'd0;
            denom_q    <= 32'd0;
            rm_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            num_q      <= num_d;
            denom_q    <= denom_d;
            rm_q       <= rm_d;
        end
    end

    // Next-state sequencing; operands are only captured when a start is accepted in IDLE.
    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        num_d      = num_q;
        denom_d    = denom_q;
        rm_d       = rm_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d      = inputNum;
                    denom_d    = inputDenom;
                    rm_d       = rm_in;
                    iter_cnt_d = 3'd0;
                    state_d    = S_INIT_N;
                end
            end
            S_INIT_N: state_d = S_INIT_D;
            S_INIT_D: state_d = S_ITER_N;
            S_ITER_N: begin
                if (iter_cnt_q == LAST_ITER) begin
                    state_d = S_REM;
                end else begin
                    state_d = S_ITER_D;
                end
            end
            S_ITER_D: begin
                iter_cnt_d = iter_cnt_q + 3'd1;
                state_d    = S_ITER_N;
            end
            S_REM:    state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore decode of datapath enables and multiplier selects from the current state.
    always_comb begin
        en_a     = 1'b0;
        en_b     = 1'b0;
        en_rem   = 1'b0;
        sel_mux3 = 2'b00;
        sel_mux4 = 2'b00;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_INIT_N: begin
                en_a = 1'b1;
                busy = 1'b1;
            end
            S_INIT_D: begin
                en_b     = 1'b1;
                sel_mux4 = 2'b01;
                busy     = 1'b1;
            end
            S_ITER_N: begin
                en_a     = 1'b1;
                sel_mux3 = 2'b01;
                sel_mux4 = 2'b10;
                busy     = 1'b1;
            end
            S_ITER_D: begin
                en_b     = 1'b1;
                sel_mux3 = 2'b01;
                sel_mux4 = 2'b11;
                busy     = 1'b1;
            end
            S_REM: begin
                en_rem   = 1'b1;
                sel_mux3 = 2'b10;
                sel_mux4 = 2'b10;
                busy     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign rm       = rm_q;
    assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb/tb_fpdiv_ctrl.sv - randomized self-checking bench for fpdiv_ctrl against a phase-position model
module tb_fpdiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] inputNum;
    logic [31:0] inputDenom;
    logic        rm_in;

    logic [31:0] num_q0, denom_q0, num_q1, denom_q1;
    logic        rm0, en_a0, en_b0, en_rem0, busy0, done0;
    logic        rm1, en_a1, en_b1, en_rem1, busy1, done1;
    logic [1:0]  s3_0, s4_0, s3_1, s4_1;
    logic [2:0]  it0, it1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpdiv_ctrl #(.NUM_ITER(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .inputNum(inputNum),
        .inputDenom(inputDenom), .rm_in(rm_in), .num_q(num_q0), .denom_q(denom_q0),
        .rm(rm0), .en_a(en_a0), .en_b(en_b0), .en_rem(en_rem0), .sel_mux3(s3_0),
        .sel_mux4(s4_0), .busy(busy0), .done(done0), .iter_cnt(it0)
    );

    fpdiv_ctrl #(.NUM_ITER(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .inputNum(inputNum),
        .inputDenom(inputDenom), .rm_in(rm_in), .num_q(num_q1), .denom_q(denom_q1),
        .rm(rm1), .en_a(en_a1), .en_b(en_b1), .en_rem(en_rem1), .sel_mux3(s3_1),
        .sel_mux4(s4_1), .busy(busy1), .done(done1), .iter_cnt(it1)
    );

    // Model state per instance: position within an operation (0 = idle, 1..2n+3 = cycle after start).
    int          n_iter [2] = '{3, 1};
    int          pos    [2];
    int          m_iter [2];
    logic [31:0] m_num  [2];
    logic [31:0] m_den  [2];
    logic        m_rm   [2];
    int          cnt_a  [2];
    int          cnt_b  [2];
    int          cnt_r  [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {en_a,en_b,en_rem,sel3,sel4,busy,done} at position p of an n-iteration operation.
    function automatic logic [8:0] exp_out(input int n, input int p);
        if (p == 0)              return 9'b000_00_00_0_0;
        if (p == 1)              return 9'b100_00_00_1_0;
        if (p == 2)              return 9'b010_00_01_1_0;
        if (p <= 2 * n + 1)      return (p % 2 == 1) ? 9'b100_01_10_1_0 : 9'b010_01_11_1_0;
        if (p == 2 * n + 2)      return 9'b001_10_10_1_0;
        return 9'b000_00_00_0_1;
    endfunction

    task automatic model_edge(input int k, input logic st, input logic rs);
        int len;
        len = 2 * n_iter[k] + 3;
        if (rs) begin
            pos[k] = 0; m_iter[k] = 0; m_num[k] = 0; m_den[k] = 0; m_rm[k] = 0;
            cnt_a[k] = 0; cnt_b[k] = 0; cnt_r[k] = 0;
        end else if (pos[k] == 0) begin
            if (st) begin
                pos[k] = 1; m_iter[k] = 0;
                m_num[k] = inputNum; m_den[k] = inputDenom; m_rm[k] = rm_in;
                cnt_a[k] = 0; cnt_b[k] = 0; cnt_r[k] = 0;
            end
        end else if (pos[k] == len) begin
            pos[k] = 0;
        end else begin
            pos[k]++;
            if (pos[k] >= 3) begin
                m_iter[k] = (pos[k] - 3) / 2;
                if (m_iter[k] > n_iter[k] - 1) m_iter[k] = n_iter[k] - 1;
            end
        end
    endtask

    task automatic check_dut(input int k);
        logic [8:0]  ov;
        logic [2:0]  oi;
        logic [31:0] on, od;
        logic        orm;
        string       pre;
        pre = (k == 0) ? "n3" : "n1";
        if (k == 0) begin
            ov = {en_a0, en_b0, en_rem0, s3_0, s4_0, busy0, done0};
            oi = it0; on = num_q0; od = denom_q0; orm = rm0;
        end else begin
            ov = {en_a1, en_b1, en_rem1, s3_1, s4_1, busy1, done1};
            oi = it1; on = num_q1; od = denom_q1; orm = rm1;
        end
        cnt_a[k] += int'(ov[8]);
        cnt_b[k] += int'(ov[7]);
        cnt_r[k] += int'(ov[6]);
        chk({pre, "_ctrl"},  64'(ov),  64'(exp_out(n_iter[k], pos[k])));
        chk({pre, "_iter"},  64'(oi),  64'(m_iter[k]));
        chk({pre, "_num"},   64'(on),  64'(m_num[k]));
        chk({pre, "_denom"}, 64'(od),  64'(m_den[k]));
        chk({pre, "_rm"},    64'(orm), 64'(m_rm[k]));
        if (pos[k] == 2 * n_iter[k] + 3) begin
            chk({pre, "_pulses_a"},   64'(cnt_a[k]), 64'(n_iter[k] + 1));
            chk({pre, "_pulses_b"},   64'(cnt_b[k]), 64'(n_iter[k]));
            chk({pre, "_pulses_rem"}, 64'(cnt_r[k]), 64'(1));
        end
    endtask

    // One clock: drive inputs, advance the model over the edge, then sample 1 ns after the edge.
    task automatic step(input logic st, input logic rs, input logic [31:0] nv,
                        input logic [31:0] dv, input logic rv);
        start = st; reset = rs; inputNum = nv; inputDenom = dv; rm_in = rv;
        model_edge(0, st, rs);
        model_edge(1, st, rs);
        @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            pos[k] = 0; m_iter[k] = 0; m_num[k] = 0; m_den[k] = 0; m_rm[k] = 0;
            cnt_a[k] = 0; cnt_b[k] = 0; cnt_r[k] = 0;
        end
        start = 0; reset = 1; inputNum = 0; inputDenom = 0; rm_in = 0;
        @(negedge clk);

        // Reset held two cycles while start is high.
        step(1, 1, 32'h3FC00000, 32'h40000000, 1);
        step(1, 1, 32'h3FC00000, 32'h40000000, 1);

        // Nominal run; operands change at cycle 3, extra starts at cycles 4 and 9.
        step(1, 0, 32'h3FC00000, 32'h40000000, 1);
        for (int c = 1; c <= 10; c++) begin
            step((c == 4 || c == 9), 0,
                 (c >= 3) ? 32'h12345678 : 32'h3FC00000, 32'h40000000, (c >= 3) ? 1'b0 : 1'b1);
        end
        for (int c = 0; c < 12; c++) step(0, 0, 32'h0, 32'h0, 0);

        // Reset during cycle 5 of a run, then a fresh full operation.
        step(1, 0, 32'h3F800000, 32'h40400000, 1);
        for (int c = 1; c <= 6; c++) step(0, (c == 5), 32'h3F800000, 32'h40400000, 1);
        step(1, 0, 32'h40A00000, 32'h3F000000, 0);
        for (int c = 1; c <= 12; c++) step(0, 0, 32'h0, 32'h0, 0);

        // Start held high: operations back to back.
        for (int c = 0; c < 45; c++) step(1, 0, $urandom, $urandom, 1'($urandom));

        // Random starts, operands and occasional resets.
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
                 $urandom, $urandom, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
